// File: rtl/player_input_sequencer_pkg.sv
// Shared types and constants for the player input sequencer.
// Holds the channel geometry, FSM state type and the one-hot grant helper.
package game_pkg;

   localparam int N_PLAYERS = 6;
   localparam int SEL_W     = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_GAP
   } seq_state_t;

   // Isolates the lowest set bit (two's-complement trick).
   function automatic logic [N_PLAYERS-1:0] lowest_onehot(input logic [N_PLAYERS-1:0] v);
      return v & (~v + N_PLAYERS'(1));
   endfunction

endpackage

// File: rtl/player_input_sequencer_if.sv
// Button/choice inputs and strobe/data outputs of the player input sequencer.
// master drives the raw buttons and choices; slave is the sequencer itself.
interface player_input_sequencer_if;
   import game_pkg::*;

   logic [N_PLAYERS-1:0]       btn;
   logic [N_PLAYERS*SEL_W-1:0] sel;
   logic [N_PLAYERS-1:0]       player_clk;
   logic [N_PLAYERS*SEL_W-1:0] player_sel;
   logic                       busy;
   logic [7:0]                 drop_cnt;

   modport master (
      output btn, sel,
      input  player_clk, player_sel, busy, drop_cnt
   );

   modport slave (
      input  btn, sel,
      output player_clk, player_sel, busy, drop_cnt
   );

endinterface

// File: rtl/player_input_sequencer_btn_debounce.sv
// One player channel: 2-FF synchroniser on button and choice, debounce counter,
// and a press flag on the edge where the debounced level rises.
module btn_debounce
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             btn,
   input  logic [SEL_W-1:0] sel,
   output logic             press,
   output logic [SEL_W-1:0] press_sel
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             btn_s1_reg;
   logic             btn_s2_reg;
   logic             level_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [SEL_W-1:0] sel_s1_reg;
   logic [SEL_W-1:0] sel_s2_reg;
   logic             differ;
   logic             settle;

   assign differ = (btn_s2_reg != level_reg);
   // The sample arriving now is the last of DEBOUNCE_CYC differing ones.
   assign settle = differ && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1_reg <= 1'b0;
         btn_s2_reg <= 1'b0;
         sel_s1_reg <= '0;
         sel_s2_reg <= '0;
         level_reg  <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         btn_s1_reg <= btn;
         btn_s2_reg <= btn_s1_reg;
         sel_s1_reg <= sel;
         sel_s2_reg <= sel_s1_reg;
         if (!differ) begin
            cnt_reg <= '0;
         end else if (settle) begin
            cnt_reg   <= '0;
            level_reg <= btn_s2_reg;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign press     = settle && btn_s2_reg;
   assign press_sel = sel_s2_reg;

endmodule

// File: rtl/player_input_sequencer.sv
// Conditions six player buttons and drives clean, setup-safe strobes to the game core.
// Define SIMUL_PRESS_EN to grant all pending players together instead of lowest-first.
module player_input_sequencer
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16,
   parameter int PULSE_CYC    = 2,
   parameter int GAP_CYC      = 2
)(
   input logic                     clk,
   input logic                     reset,
   player_input_sequencer_if.slave bus
);

   localparam int PHASE_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int PH_W      = $clog2(PHASE_MAX) + 1;
   localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_CYC - 1);
   localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_CYC - 1);

   logic [N_PLAYERS-1:0]            press;
   logic [N_PLAYERS-1:0][SEL_W-1:0] press_sel;
   logic [N_PLAYERS-1:0][SEL_W-1:0] cap_sel_reg;
   logic [N_PLAYERS-1:0]            pending_reg;
   logic [N_PLAYERS-1:0]            grant_reg;
   logic [N_PLAYERS-1:0]            take;
   logic [N_PLAYERS-1:0]            merge_vec;
   logic [8:0]                      drop_sum;
   seq_state_t                      state_reg;
   logic [PH_W-1:0]                 phase_cnt_reg;
   logic [N_PLAYERS-1:0]            player_clk_reg;
   logic [N_PLAYERS-1:0][SEL_W-1:0] player_sel_reg;
   logic                            busy_reg;
   logic [7:0]                      drop_cnt_reg;

   generate
      for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_chan
         btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
         ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .btn      (bus.btn[gi]),
            .sel      (bus.sel[gi*SEL_W +: SEL_W]),
            .press    (press[gi]),
            .press_sel(press_sel[gi])
         );
      end
   endgenerate

   // Grant set, only meaningful while the FSM sits in IDLE.
   always_comb begin
      take = '0;
      if (state_reg == S_IDLE) begin
`ifdef SIMUL_PRESS_EN
         take = pending_reg;
`else
         take = lowest_onehot(pending_reg);
`endif
      end
   end

   // A press on a channel being granted this cycle is a fresh request, not a merge.
   assign merge_vec = press & pending_reg & ~take;
   assign drop_sum  = {1'b0, drop_cnt_reg} + 9'($countones(merge_vec));

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_reg  <= '0;
         cap_sel_reg  <= '0;
         drop_cnt_reg <= '0;
      end else begin
         pending_reg  <= (pending_reg & ~take) | press;
         drop_cnt_reg <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         for (int i = 0; i < N_PLAYERS; i++) begin
            if (press[i]) begin
               cap_sel_reg[i] <= press_sel[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         grant_reg      <= '0;
         phase_cnt_reg  <= '0;
         player_clk_reg <= '0;
         player_sel_reg <= '0;
         busy_reg       <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (|take) begin
                  grant_reg <= take;
                  for (int i = 0; i < N_PLAYERS; i++) begin
                     if (take[i]) begin
                        player_sel_reg[i] <= cap_sel_reg[i];
                     end
                  end
                  busy_reg  <= 1'b1;
                  state_reg <= S_SETUP;
               end
            end
            S_SETUP: begin
               player_clk_reg <= grant_reg;
               phase_cnt_reg  <= '0;
               state_reg      <= S_PULSE;
            end
            S_PULSE: begin
               if (phase_cnt_reg == PULSE_LAST) begin
                  player_clk_reg <= '0;
                  phase_cnt_reg  <= '0;
                  state_reg      <= S_GAP;
               end else begin
                  phase_cnt_reg <= phase_cnt_reg + PH_W'(1);
               end
            end
            S_GAP: begin
               if (phase_cnt_reg == GAP_LAST) begin
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end else begin
                  phase_cnt_reg <= phase_cnt_reg + PH_W'(1);
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.player_clk = player_clk_reg;
   assign bus.player_sel = player_sel_reg;
   assign bus.busy       = busy_reg;
   assign bus.drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_player_input_sequencer.sv
// Bench for player_input_sequencer: directed button scenarios, a behavioural timeline
// model checked every cycle, and literal expectations for each scenario.
module tb_player_input_sequencer;

   localparam int D  = 16;
   localparam int PW = 2;
   localparam int GW = 80;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   player_input_sequencer_if pif();

   player_input_sequencer #(
      .DEBOUNCE_CYC(D),
      .PULSE_CYC   (PW),
      .GAP_CYC     (GW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (pif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: delay-line synchroniser, sliding-window debounce,
   // pending set and a round timeline (decide, setup, PW strobe, GW gap).
   logic [5:0] m_bd1, m_bd2, m_lvl, m_pend, m_grant;
   logic [2:0] m_sd1 [6];
   logic [2:0] m_sd2 [6];
   logic [2:0] m_cap [6];
   logic [2:0] m_psel [6];
   logic [5:0] m_win [$];
   bit         m_busy;
   int         m_t;
   int         m_drops;

   always @(posedge clk) begin : model
      logic [5:0] press, g;
      logic [2:0] ssmp [6];
      bit         all_new;
      if (reset) begin
         m_bd1 = '0; m_bd2 = '0; m_lvl = '0; m_pend = '0; m_grant = '0;
         m_win.delete();
         m_busy = 0; m_t = 0; m_drops = 0;
         for (int i = 0; i < 6; i++) begin
            m_sd1[i] = '0; m_sd2[i] = '0; m_cap[i] = '0; m_psel[i] = '0;
         end
      end else begin
         for (int i = 0; i < 6; i++) ssmp[i] = m_sd2[i];
         m_win.push_back(m_bd2);
         if (m_win.size() > D) void'(m_win.pop_front());
         press = '0;
         if (m_win.size() == D) begin
            for (int i = 0; i < 6; i++) begin
               all_new = 1;
               foreach (m_win[j]) if (m_win[j][i] == m_lvl[i]) all_new = 0;
               if (all_new) begin
                  m_lvl[i] = ~m_lvl[i];
                  press[i] = m_lvl[i];
               end
            end
         end
         g = '0;
         if (!m_busy && m_pend != 0) begin
`ifdef SIMUL_PRESS_EN
            g = m_pend;
`else
            for (int i = 5; i >= 0; i--) if (m_pend[i]) g = 6'(1) << i;
`endif
         end
         for (int i = 0; i < 6; i++) if (g[i]) m_psel[i] = m_cap[i];
         for (int i = 0; i < 6; i++) begin
            if (press[i]) begin
               if (m_pend[i] && !g[i]) m_drops++;
               m_cap[i] = ssmp[i];
            end
         end
         m_pend = (m_pend & ~g) | press;
         if (!m_busy) begin
            if (g != 0) begin
               m_busy = 1; m_t = 0; m_grant = g;
            end
         end else if (m_t == PW + GW) begin
            m_busy = 0;
         end else begin
            m_t++;
         end
         m_bd2 = m_bd1;
         m_bd1 = pif.btn;
         for (int i = 0; i < 6; i++) begin
            m_sd2[i] = m_sd1[i];
            m_sd1[i] = pif.sel[3*i +: 3];
         end
      end
   end

   logic [5:0]  obs [$];
   logic [17:0] obs_sel [$];
   logic [5:0]  prev_clk = '0;

   always @(negedge clk) begin : compare
      logic [5:0]  e_clk;
      logic [17:0] e_sel;
      logic [7:0]  e_drop;
      e_clk = (m_busy && m_t >= 1 && m_t <= PW) ? m_grant : 6'd0;
      for (int i = 0; i < 6; i++) e_sel[3*i +: 3] = m_psel[i];
      e_drop = (m_drops > 255) ? 8'd255 : 8'(m_drops);
      check("player_clk", 32'(pif.player_clk), 32'(e_clk));
      check("player_sel", 32'(pif.player_sel), 32'(e_sel));
      check("busy", 32'(pif.busy), 32'(m_busy));
      check("drop_cnt", 32'(pif.drop_cnt), 32'(e_drop));
      if (pif.player_clk != 0 && prev_clk == 0) begin
         obs.push_back(pif.player_clk);
         obs_sel.push_back(pif.player_sel);
         $display("strobe mask=%06b sel=%o drop_cnt=%0d t=%0t",
                  pif.player_clk, pif.player_sel, pif.drop_cnt, $time);
      end
      prev_clk = pif.player_clk;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_ch(input int ch, input logic [2:0] s, input int hold, input int rel);
      pif.sel[3*ch +: 3] = s;
      pif.btn[ch] = 1'b1;
      cycles(hold);
      pif.btn[ch] = 1'b0;
      cycles(rel);
   endtask

   initial begin
      int n;
      pif.btn = '0;
      pif.sel = '0;
      reset   = 1'b1;
      cycles(3);
      check("rst_clk", 32'(pif.player_clk), 32'h0);
      check("rst_sel", 32'(pif.player_sel), 32'h0);
      check("rst_busy", 32'(pif.busy), 32'h0);
      check("rst_drop", 32'(pif.drop_cnt), 32'h0);
      reset = 1'b0;
      cycles(5);

      // 1: single press on player 3, exact timing of data and strobe
      obs.delete(); obs_sel.delete();
      pif.sel[8:6] = 3'b101;
      pif.btn[2]   = 1'b1;
      cycles(19);
      check("t1_pre_clk", 32'(pif.player_clk), 32'h0);
      check("t1_pre_sel", 32'(pif.player_sel[8:6]), 32'h5);
      cycles(1);
      check("t1_clk_a", 32'(pif.player_clk), 32'h04);
      cycles(1);
      check("t1_clk_b", 32'(pif.player_clk), 32'h04);
      cycles(1);
      check("t1_clk_end", 32'(pif.player_clk), 32'h0);
      pif.btn[2] = 1'b0;
      cycles(120);
      check("t1_count", 32'(obs.size()), 32'd1);

      // 2: bouncing button settles into exactly one strobe
      obs.delete(); obs_sel.delete();
      pif.sel[2:0] = 3'b011;
      for (int k = 0; k < 5; k++) begin
         pif.btn[0] = 1'b1; cycles(3);
         pif.btn[0] = 1'b0; cycles(3);
      end
      check("t2_no_early", 32'(obs.size()), 32'd0);
      pif.btn[0] = 1'b1;
      cycles(20);
      check("t2_clk", 32'(pif.player_clk), 32'h01);
      cycles(2);
      pif.btn[0] = 1'b0;
      cycles(120);
      check("t2_count", 32'(obs.size()), 32'd1);

      // 3: two players debounced on the same cycle
      obs.delete(); obs_sel.delete();
      pif.sel[5:3]   = 3'b110;
      pif.sel[14:12] = 3'b001;
      pif.btn[1] = 1'b1;
      pif.btn[4] = 1'b1;
      cycles(20);
      pif.btn[1] = 1'b0;
      pif.btn[4] = 1'b0;
      cycles(220);
`ifdef SIMUL_PRESS_EN
      check("t3_count", 32'(obs.size()), 32'd1);
      if (obs.size() >= 1) check("t3_mask0", 32'(obs[0]), 32'h12);
`else
      check("t3_count", 32'(obs.size()), 32'd2);
      if (obs.size() >= 1) check("t3_mask0", 32'(obs[0]), 32'h02);
      if (obs.size() >= 2) check("t3_mask1", 32'(obs[1]), 32'h10);
`endif

      // 4: two more presses during the in-flight round on player 4
      obs.delete(); obs_sel.delete();
      press_ch(3, 3'b001, 18, 18);
      press_ch(3, 3'b010, 18, 18);
      press_ch(3, 3'b110, 18, 18);
      cycles(150);
      check("t4_count", 32'(obs.size()), 32'd2);
      if (obs.size() >= 2) begin
         check("t4_mask1", 32'(obs[1]), 32'h08);
         check("t4_sel0", 32'(obs_sel[0][11:9]), 32'h1);
         check("t4_sel1", 32'(obs_sel[1][11:9]), 32'h6);
      end
      check("t4_drop", 32'(pif.drop_cnt), 32'd1);

      // 5: reset in the second strobe cycle
      pif.btn[1] = 1'b1;
      pif.btn[5] = 1'b1;
      n = 0;
      while (pif.player_clk == 0 && n < 40) begin
         cycles(1);
         n++;
      end
      check("t5_strobe_seen", 32'(pif.player_clk != 0), 32'd1);
      cycles(1);
      reset = 1'b1;
      pif.btn = '0;
      cycles(1);
      check("t5_clk", 32'(pif.player_clk), 32'h0);
      check("t5_busy", 32'(pif.busy), 32'h0);
      check("t5_drop", 32'(pif.drop_cnt), 32'h0);
      reset = 1'b0;
      cycles(2);
      obs.delete(); obs_sel.delete();
      cycles(60);
      check("t5_no_strobe", 32'(obs.size()), 32'd0);

      // 6: sustained repeated presses saturate the merge counter
      for (int k = 0; k < 520; k++) begin
         press_ch(0, 3'(k), 18, 18);
      end
      cycles(200);
      check("t6_drop_sat", 32'(pif.drop_cnt), 32'd255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
